// File: rtl/mc_control.sv
// Multi-cycle RISC-V control unit: state register plus combinational decode
// of datapath selects, ALU op and write strobes from state and instruction fields.
module mc_control (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       adrsrc,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic [1:0] resultsrc,
   output logic [1:0] alusrca,
   output logic [1:0] alusrcb,
   output logic [2:0] aluctr,
   output logic       halted,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_HALT     = 4'd11
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   state_t     state_q;
   state_t     state_d;
   logic [2:0] alu_dec;
   logic       alu_ok;
   logic       pcwrite_c;
   logic       irwrite_c;
   logic       memwrite_c;
   logic       regwrite_c;

   // State register; reset forces FETCH without waiting for an edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // ALU op from funct3; subtract only for register-register with bit 30 set
   always_comb begin
      alu_dec = ALU_ADD;
      alu_ok  = 1'b1;
      case (funct3)
         3'b000:  alu_dec = (state_q == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  alu_dec = ALU_SLT;
         3'b110:  alu_dec = ALU_OR;
         3'b111:  alu_dec = ALU_AND;
         default: alu_ok  = 1'b0;
      endcase
   end

   // Next state and datapath controls
   always_comb begin
      state_d    = state_q;
      pcwrite_c  = 1'b0;
      irwrite_c  = 1'b0;
      memwrite_c = 1'b0;
      regwrite_c = 1'b0;
      adrsrc     = 1'b0;
      resultsrc  = RES_ALUOUT;
      alusrca    = SRCA_PC;
      alusrcb    = SRCB_RS2;
      aluctr     = ALU_AND;
      halted     = 1'b0;
      case (state_q)
         S_FETCH: begin
            alusrca   = SRCA_PC;
            alusrcb   = SRCB_FOUR;
            aluctr    = ALU_ADD;
            resultsrc = RES_ALU;
            irwrite_c = mem_ready;
            pcwrite_c = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            alusrca = SRCA_OLDPC;
            alusrcb = SRCB_IMM;
            aluctr  = ALU_ADD;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_HALT;
            endcase
         end
         S_MEMADR: begin
            alusrca = SRCA_RS1;
            alusrcb = SRCB_IMM;
            aluctr  = ALU_ADD;
            state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adrsrc = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            resultsrc  = RES_MEM;
            regwrite_c = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            adrsrc     = 1'b1;
            memwrite_c = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXECR, S_EXECI: begin
            alusrca = SRCA_RS1;
            alusrcb = (state_q == S_EXECI) ? SRCB_IMM : SRCB_RS2;
            aluctr  = alu_dec;
            state_d = alu_ok ? S_ALUWB : S_HALT;
         end
         S_ALUWB: begin
            resultsrc  = RES_ALUOUT;
            regwrite_c = 1'b1;
            state_d    = S_FETCH;
         end
         S_BEQ: begin
            alusrca   = SRCA_RS1;
            alusrcb   = SRCB_RS2;
            aluctr    = ALU_SUB;
            resultsrc = RES_ALUOUT;
            if (funct3 == 3'b000) begin
               pcwrite_c = zero;
               state_d   = S_FETCH;
            end else begin
               state_d   = S_HALT;
            end
         end
         S_JAL: begin
            alusrca   = SRCA_OLDPC;
            alusrcb   = SRCB_FOUR;
            aluctr    = ALU_ADD;
            resultsrc = RES_ALUOUT;
            pcwrite_c = 1'b1;
            state_d   = S_ALUWB;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            halted  = 1'b1;
            state_d = S_HALT;
         end
      endcase
   end

   // Strobes are suppressed while reset is held, even though FETCH selects show
   assign pcwrite  = pcwrite_c  & rst_n;
   assign irwrite  = irwrite_c  & rst_n;
   assign memwrite = memwrite_c & rst_n;
   assign regwrite = regwrite_c & rst_n;
   assign state    = 4'(state_q);

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: stimulus pushes the expected control vector
// for each cycle, a monitor pops and compares it mid-cycle.
module tb_mc_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       mem_ready;
   logic       pcwrite, adrsrc, irwrite, memwrite, regwrite, halted;
   logic [1:0] resultsrc, alusrca, alusrcb;
   logic [2:0] aluctr;
   logic [3:0] state;

   always #5 clk = ~clk;

   mc_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
      .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
      .pcwrite(pcwrite), .adrsrc(adrsrc), .irwrite(irwrite),
      .memwrite(memwrite), .regwrite(regwrite), .resultsrc(resultsrc),
      .alusrca(alusrca), .alusrcb(alusrcb), .aluctr(aluctr),
      .halted(halted), .state(state)
   );

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   // {state, pcwrite, adrsrc, irwrite, memwrite, regwrite, resultsrc, alusrca, alusrcb, aluctr, halted}
   localparam logic [18:0] E_FETCH1   = {4'd0,  5'b10100, 2'b10, 2'b00, 2'b10, 3'b010, 1'b0};
   localparam logic [18:0] E_FETCH0   = {4'd0,  5'b00000, 2'b10, 2'b00, 2'b10, 3'b010, 1'b0};
   localparam logic [18:0] E_DECODE   = {4'd1,  5'b00000, 2'b00, 2'b01, 2'b01, 3'b010, 1'b0};
   localparam logic [18:0] E_MEMADR   = {4'd2,  5'b00000, 2'b00, 2'b10, 2'b01, 3'b010, 1'b0};
   localparam logic [18:0] E_MEMREAD  = {4'd3,  5'b01000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
   localparam logic [18:0] E_MEMWB    = {4'd4,  5'b00001, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0};
   localparam logic [18:0] E_MEMWRITE = {4'd5,  5'b01010, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
   localparam logic [18:0] E_ALUWB    = {4'd8,  5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0};
   localparam logic [18:0] E_BEQ1     = {4'd9,  5'b10000, 2'b00, 2'b10, 2'b00, 3'b110, 1'b0};
   localparam logic [18:0] E_BEQ0     = {4'd9,  5'b00000, 2'b00, 2'b10, 2'b00, 3'b110, 1'b0};
   localparam logic [18:0] E_JAL      = {4'd10, 5'b10000, 2'b00, 2'b01, 2'b10, 3'b010, 1'b0};
   localparam logic [18:0] E_HALT     = {4'd11, 5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1};

   function automatic logic [18:0] e_execr(input logic [2:0] ac);
      return {4'd6, 5'b00000, 2'b00, 2'b10, 2'b00, ac, 1'b0};
   endfunction

   function automatic logic [18:0] e_execi(input logic [2:0] ac);
      return {4'd7, 5'b00000, 2'b00, 2'b10, 2'b01, ac, 1'b0};
   endfunction

   logic [18:0] act;
   assign act = {state, pcwrite, adrsrc, irwrite, memwrite, regwrite,
                 resultsrc, alusrca, alusrcb, aluctr, halted};

   logic [18:0] exp_q[$];
   string       name_q[$];
   int          n_pass    = 0;
   int          n_checks  = 0;
   int          n_timeout = 0;

   // Monitor: compare one queued expectation per cycle, mid-cycle
   initial begin
      logic [18:0] e;
      string       nm;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (act === e) n_pass++;
            else $display("FAIL %s: got %05h (state %0d) expected %05h (state %0d)",
                          nm, act, act[18:15], e, e[18:15]);
         end
      end
   end

   task automatic ins(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      opcode   = op;
      funct3   = f3;
      funct7b5 = f7;
   endtask

   // One cycle: drive inputs after the edge and queue the expected vector
   task automatic step(input string nm, input logic mr, input logic z,
                       input logic rn, input logic [18:0] e);
      @(posedge clk);
      #1;
      mem_ready = mr;
      zero      = z;
      rst_n     = rn;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   initial begin
      rst_n = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
      zero = 1'b0; mem_ready = 1'b0;
      #1 rst_n = 1'b0;
      step("rst_hold", 1'b1, 1'b0, 1'b0, E_FETCH0);

      // lw, no waits: 0,1,2,3,4
      ins(OP_LW, 3'b010, 1'b0);
      step("lw_fetch",   1'b1, 1'b0, 1'b1, E_FETCH1);
      step("lw_decode",  1'b1, 1'b0, 1'b1, E_DECODE);
      step("lw_memadr",  1'b1, 1'b0, 1'b1, E_MEMADR);
      step("lw_memread", 1'b1, 1'b0, 1'b1, E_MEMREAD);
      step("lw_memwb",   1'b1, 1'b0, 1'b1, E_MEMWB);

      // sw with a fetch wait, ignored mem_ready in decode/memadr, three write waits
      ins(OP_SW, 3'b010, 1'b0);
      step("sw_fetch_wait", 1'b0, 1'b0, 1'b1, E_FETCH0);
      step("sw_fetch",      1'b1, 1'b0, 1'b1, E_FETCH1);
      step("sw_decode",     1'b0, 1'b0, 1'b1, E_DECODE);
      step("sw_memadr",     1'b0, 1'b0, 1'b1, E_MEMADR);
      step("sw_wr_wait1",   1'b0, 1'b0, 1'b1, E_MEMWRITE);
      step("sw_wr_wait2",   1'b0, 1'b0, 1'b1, E_MEMWRITE);
      step("sw_wr_wait3",   1'b0, 1'b0, 1'b1, E_MEMWRITE);
      step("sw_wr_done",    1'b1, 1'b0, 1'b1, E_MEMWRITE);

      // ALU decode variants
      ins(OP_R, 3'b000, 1'b1);
      step("sub_fetch",  1'b1, 1'b0, 1'b1, E_FETCH1);
      step("sub_decode", 1'b1, 1'b0, 1'b1, E_DECODE);
      step("sub_execr",  1'b1, 1'b0, 1'b1, e_execr(3'b110));
      step("sub_aluwb",  1'b1, 1'b0, 1'b1, E_ALUWB);
      ins(OP_I, 3'b000, 1'b1);
      step("addi_fetch",  1'b1, 1'b0, 1'b1, E_FETCH1);
      step("addi_decode", 1'b1, 1'b0, 1'b1, E_DECODE);
      step("addi_execi",  1'b1, 1'b0, 1'b1, e_execi(3'b010));
      step("addi_aluwb",  1'b1, 1'b0, 1'b1, E_ALUWB);
      ins(OP_R, 3'b010, 1'b0);
      step("slt_fetch",  1'b1, 1'b0, 1'b1, E_FETCH1);
      step("slt_decode", 1'b1, 1'b0, 1'b1, E_DECODE);
      step("slt_execr",  1'b1, 1'b0, 1'b1, e_execr(3'b111));
      step("slt_aluwb",  1'b1, 1'b0, 1'b1, E_ALUWB);
      ins(OP_I, 3'b110, 1'b0);
      step("ori_fetch",  1'b1, 1'b0, 1'b1, E_FETCH1);
      step("ori_decode", 1'b1, 1'b0, 1'b1, E_DECODE);
      step("ori_execi",  1'b1, 1'b0, 1'b1, e_execi(3'b001));
      step("ori_aluwb",  1'b1, 1'b0, 1'b1, E_ALUWB);
      ins(OP_R, 3'b111, 1'b0);
      step("and_fetch",  1'b1, 1'b0, 1'b1, E_FETCH1);
      step("and_decode", 1'b1, 1'b0, 1'b1, E_DECODE);
      step("and_execr",  1'b1, 1'b0, 1'b1, e_execr(3'b000));
      step("and_aluwb",  1'b1, 1'b0, 1'b1, E_ALUWB);

      // beq taken and not taken
      ins(OP_BEQ, 3'b000, 1'b0);
      step("beq1_fetch",  1'b1, 1'b1, 1'b1, E_FETCH1);
      step("beq1_decode", 1'b1, 1'b1, 1'b1, E_DECODE);
      step("beq1_beq",    1'b1, 1'b1, 1'b1, E_BEQ1);
      step("beq0_fetch",  1'b1, 1'b0, 1'b1, E_FETCH1);
      step("beq0_decode", 1'b1, 1'b0, 1'b1, E_DECODE);
      step("beq0_beq",    1'b1, 1'b0, 1'b1, E_BEQ0);

      // jal
      ins(OP_JAL, 3'b000, 1'b0);
      step("jal_fetch",  1'b1, 1'b0, 1'b1, E_FETCH1);
      step("jal_decode", 1'b1, 1'b0, 1'b1, E_DECODE);
      step("jal_jal",    1'b1, 1'b0, 1'b1, E_JAL);
      step("jal_aluwb",  1'b1, 1'b0, 1'b1, E_ALUWB);

      // reset mid-MEMREAD wait
      ins(OP_LW, 3'b010, 1'b0);
      step("rlw_fetch",   1'b1, 1'b0, 1'b1, E_FETCH1);
      step("rlw_decode",  1'b1, 1'b0, 1'b1, E_DECODE);
      step("rlw_memadr",  1'b0, 1'b0, 1'b1, E_MEMADR);
      step("rlw_memread", 1'b0, 1'b0, 1'b1, E_MEMREAD);
      step("rlw_async",   1'b0, 1'b0, 1'b0, E_FETCH0);
      step("rlw_hold",    1'b1, 1'b0, 1'b0, E_FETCH0);

      // reset mid-MEMWRITE wait
      ins(OP_SW, 3'b010, 1'b0);
      step("rsw_fetch",  1'b1, 1'b0, 1'b1, E_FETCH1);
      step("rsw_decode", 1'b1, 1'b0, 1'b1, E_DECODE);
      step("rsw_memadr", 1'b0, 1'b0, 1'b1, E_MEMADR);
      step("rsw_wait",   1'b0, 1'b0, 1'b1, E_MEMWRITE);
      step("rsw_async",  1'b0, 1'b0, 1'b0, E_FETCH0);

      // unsupported funct3 in EXECR halts
      ins(OP_R, 3'b001, 1'b0);
      step("badr_fetch",  1'b1, 1'b0, 1'b1, E_FETCH1);
      step("badr_decode", 1'b1, 1'b0, 1'b1, E_DECODE);
      step("badr_execr",  1'b1, 1'b0, 1'b1, e_execr(3'b010));
      step("badr_halt",   1'b1, 1'b0, 1'b1, E_HALT);
      step("badr_rst",    1'b1, 1'b0, 1'b0, E_FETCH0);

      // beq with bad funct3 halts without branching
      ins(OP_BEQ, 3'b001, 1'b0);
      step("badb_fetch",  1'b1, 1'b1, 1'b1, E_FETCH1);
      step("badb_decode", 1'b1, 1'b1, 1'b1, E_DECODE);
      step("badb_beq",    1'b1, 1'b1, 1'b1, E_BEQ0);
      step("badb_halt",   1'b1, 1'b1, 1'b1, E_HALT);
      step("badb_rst",    1'b1, 1'b1, 1'b0, E_FETCH0);

      // illegal opcode: HALT is sticky until reset
      ins(OP_BAD, 3'b000, 1'b0);
      step("bad_fetch",  1'b1, 1'b1, 1'b1, E_FETCH1);
      step("bad_decode", 1'b1, 1'b1, 1'b1, E_DECODE);
      for (int i = 0; i < 12; i++) step("bad_halt", 1'b1, 1'b1, 1'b1, E_HALT);
      step("bad_rst", 1'b1, 1'b1, 1'b0, E_FETCH0);
      ins(OP_JAL, 3'b000, 1'b0);
      step("post_fetch",  1'b1, 1'b0, 1'b1, E_FETCH1);
      step("post_decode", 1'b1, 1'b0, 1'b1, E_DECODE);
      step("post_jal",    1'b1, 1'b0, 1'b1, E_JAL);

      for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_timeout++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks + n_timeout);
      $finish;
   end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameters: none; all encodings below are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  7  instruction opcode from instruction register.
REQ-005 funct3  input  3  instruction funct3.
REQ-006 funct7b5  input  1  instruction bit 30.
REQ-007 zero  input  1  ALU zero flag from the current-cycle ALU result.
REQ-008 mem_ready  input  1  memory handshake; access completes in the cycle it is high.
REQ-009 pcwrite  output  1  PC register load enable.
REQ-010 adrsrc  output  1  memory address select: 0 = PC, 1 = ALU output register.
REQ-011 irwrite  output  1  instruction register load enable.
REQ-012 memwrite  output  1  memory write request.
REQ-013 regwrite  output  1  register-file write enable.
REQ-014 resultsrc  output  2  result mux: 00 = ALU output register, 01 = memory data, 10 = ALU result.
REQ-015 alusrca  output  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1.
REQ-016 alusrcb  output  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4.
REQ-017 aluctr  output  3  ALU op code: 010 = add, 110 = sub, 000 = and, 001 = or, 111 = signed slt.
REQ-018 halted  output  1  high while in HALT.
REQ-019 state  output  4  current state encoding, for debug.

Function
REQ-020 State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, HALT=11; codes 12-15 go to HALT.
REQ-021 Any output not listed for a state is 0 in that state; outputs are decoded combinationally from state and the inputs named here.
REQ-022 FETCH: adrsrc=0, alusrca=00, alusrcb=10, aluctr=010, resultsrc=10, irwrite=pcwrite=mem_ready; stay while mem_ready=0; go to DECODE when mem_ready=1.
REQ-023 DECODE (1 cycle): alusrca=01, alusrcb=01, aluctr=010; next state by opcode: 0000011 or 0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BEQ, 1101111 -> JAL, any other -> HALT.
REQ-024 MEMADR (1 cycle): alusrca=10, alusrcb=01, aluctr=010; opcode[5]=0 -> MEMREAD, opcode[5]=1 -> MEMWRITE.
REQ-025 MEMREAD: adrsrc=1; stay while mem_ready=0; go to MEMWB when mem_ready=1.
REQ-026 MEMWB (1 cycle): resultsrc=01, regwrite=1; then FETCH.
REQ-027 MEMWRITE: adrsrc=1, memwrite=1 held until mem_ready=1; then FETCH.
REQ-028 EXECR/EXECI (1 cycle): alusrca=10; alusrcb=00 for EXECR, 01 for EXECI; aluctr decoded per REQ-029; then ALUWB, or HALT if funct3 is unsupported.
REQ-029 ALU decode: funct3 000 -> 110 if (EXECR and funct7b5=1) else 010; 010 -> 111; 110 -> 001; 111 -> 000; other funct3 -> unsupported (aluctr=010, next state HALT).
REQ-030 ALUWB (1 cycle): resultsrc=00, regwrite=1; then FETCH.
REQ-031 BEQ (1 cycle): alusrca=10, alusrcb=00, aluctr=110, resultsrc=00, pcwrite=zero; then FETCH; funct3 other than 000 -> HALT with pcwrite=0.
REQ-032 JAL (1 cycle): alusrca=01, alusrcb=10, aluctr=010, resultsrc=00, pcwrite=1; then ALUWB.
REQ-033 HALT: halted=1, all enables 0; remains in HALT until reset.
REQ-034 Latencies with mem_ready always 1: lw 5 cycles, sw 4, R/I-type 4, beq 3, jal 4; each wait cycle adds 1.
REQ-035 mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.

Reset
REQ-036 rst_n low forces state to FETCH immediately, without waiting for a clock edge.
REQ-037 While rst_n is low, pcwrite, irwrite, memwrite and regwrite are 0 regardless of mem_ready; the other outputs take their FETCH values; halted=0.
REQ-038 Reset asserted mid-instruction, including during a MEMWRITE wait, abandons the instruction; the first cycle after rst_n rises is FETCH.

Verification
REQ-039 Reset, then lw (opcode 0000011) with mem_ready=1 -> state sequence 0,1,2,3,4,0; regwrite=1 only in state 4 with resultsrc=01.
REQ-040 sw (0100011), mem_ready low for 3 cycles in MEMWRITE -> memwrite=1 and adrsrc=1 for 4 cycles; regwrite never asserts; next state FETCH.
REQ-041 R-type sub (0110011, funct3 000, funct7b5=1) -> aluctr=110 in EXECR; same fields with opcode 0010011 -> aluctr=010; funct3 010 -> 111; 110 -> 001; 111 -> 000.
REQ-042 beq with zero=1 -> pcwrite=1 in BEQ; with zero=0 -> pcwrite=0; both return to FETCH after 3 cycles.
REQ-043 Opcode 1111111 in DECODE -> HALT next cycle with halted=1 and all enables 0 for 10 or more cycles; rst_n pulse -> state=0 asynchronously.
REQ-044 rst_n dropped in MEMREAD while mem_ready=0 -> state=0 before the next edge; all strobes 0 while rst_n is low.
